// File: rtl/ahb_mem_if.sv
// AHB-Lite bus bundle between one master and the word-addressed memory slave.
// Clock and reset stay outside the bundle as plain module ports.
interface ahb_mem_if;
  logic        HSEL;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  modport master (
    output HSEL, HTRANS, HWRITE, HADDR, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HSEL, HTRANS, HWRITE, HADDR, HWDATA,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/ahb_mem_slave.sv
// Word-addressed AHB-Lite memory slave with WAIT_STATES stall cycles per data phase.
// Optional macro AHB_MEM_ERROR_RESP_EN: out-of-range addresses get a two-cycle ERROR response.
module ahb_mem_slave #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic       HCLK,
  input  logic       HRESETn,
  ahb_mem_if.slave   bus
);

  localparam int         DEPTH = 1 << ADDR_WIDTH;
  localparam logic [3:0] WS    = 4'(WAIT_STATES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
`ifdef AHB_MEM_ERROR_RESP_EN
    S_DATA,
    S_ERR1,
    S_ERR2
`else
    S_DATA
`endif
  } state_t;

  logic [31:0]           r_mem [DEPTH];
  state_t                r_state;
  logic [3:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic                  r_write;
  logic                  r_hready;

  logic                  w_accept;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic                  w_unused;

  assign w_accept = bus.HSEL & bus.HTRANS[1] & r_hready;
  assign w_idx    = bus.HADDR[ADDR_WIDTH+1:2];

`ifdef AHB_MEM_ERROR_RESP_EN
  logic r_hresp;
  logic w_oor;

  assign w_oor    = |bus.HADDR[31:ADDR_WIDTH+2];
  assign w_unused = ^{bus.HTRANS[0], bus.HADDR[1:0]};
  assign bus.HRESP = r_hresp;
`else
  // Upper address bits are dropped, so accesses wrap modulo the depth.
  assign w_unused = ^{bus.HTRANS[0], bus.HADDR[1:0], bus.HADDR[31:ADDR_WIDTH+2]};
  assign bus.HRESP = 1'b0;
`endif

  // Handshake outputs are registered so they change only with the state.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_write  <= 1'b0;
      r_hready <= 1'b1;
`ifdef AHB_MEM_ERROR_RESP_EN
      r_hresp  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state  <= S_DATA;
            r_hready <= 1'b1;
          end
        end
`ifdef AHB_MEM_ERROR_RESP_EN
        S_ERR1: begin
          r_state  <= S_ERR2;
          r_hready <= 1'b1;
        end
`endif
        default: begin
          // IDLE, DATA and ERR2 all leave HREADY high, so each may accept a new address.
`ifdef AHB_MEM_ERROR_RESP_EN
          r_hresp <= 1'b0;
`endif
          if (w_accept) begin
            r_idx   <= w_idx;
            r_write <= bus.HWRITE;
`ifdef AHB_MEM_ERROR_RESP_EN
            if (w_oor) begin
              r_state  <= S_ERR1;
              r_hready <= 1'b0;
              r_hresp  <= 1'b1;
            end else
`endif
            if (WAIT_STATES > 0) begin
              r_state  <= S_WAIT;
              r_cnt    <= WS;
              r_hready <= 1'b0;
            end else begin
              r_state  <= S_DATA;
              r_hready <= 1'b1;
            end
          end else begin
            r_state  <= S_IDLE;
            r_hready <= 1'b1;
          end
        end
      endcase
    end
  end

  // NOTE: the memory array has no reset; a write is gated by S_DATA, which reset clears
  // at once, so a write interrupted by reset never reaches the array.
  always_ff @(posedge HCLK) begin
    if (r_state == S_DATA && r_write) begin
      r_mem[r_idx] <= bus.HWDATA;
    end
  end

  assign bus.HREADY = r_hready;
  assign bus.HRDATA = (r_state == S_DATA && !r_write) ? r_mem[r_idx] : 32'h0;

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Directed bench for ahb_mem_slave: three instances with 0, 1 and 3 wait states share
// one set of bus drivers; HSEL is steered to the instance under test.
module tb_ahb_mem_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hsel;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  int          sel;

  logic [31:0] o_rdata;
  logic        o_ready;
  logic        o_resp;
  logic [31:0] rd;

  int checks = 0;
  int errors = 0;

`ifdef AHB_MEM_ERROR_RESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  ahb_mem_if if_ws0 ();
  ahb_mem_if if_ws1 ();
  ahb_mem_if if_ws3 ();

  assign if_ws0.HSEL = hsel && (sel == 0);
  assign if_ws1.HSEL = hsel && (sel == 1);
  assign if_ws3.HSEL = hsel && (sel == 2);
  assign if_ws0.HTRANS = htrans;
  assign if_ws1.HTRANS = htrans;
  assign if_ws3.HTRANS = htrans;
  assign if_ws0.HWRITE = hwrite;
  assign if_ws1.HWRITE = hwrite;
  assign if_ws3.HWRITE = hwrite;
  assign if_ws0.HADDR  = haddr;
  assign if_ws1.HADDR  = haddr;
  assign if_ws3.HADDR  = haddr;
  assign if_ws0.HWDATA = hwdata;
  assign if_ws1.HWDATA = hwdata;
  assign if_ws3.HWDATA = hwdata;

  ahb_mem_slave #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u_ws0 (.HCLK(clk), .HRESETn(rst_n), .bus(if_ws0));
  ahb_mem_slave #(.ADDR_WIDTH(10), .WAIT_STATES(1)) u_ws1 (.HCLK(clk), .HRESETn(rst_n), .bus(if_ws1));
  ahb_mem_slave #(.ADDR_WIDTH(10), .WAIT_STATES(3)) u_ws3 (.HCLK(clk), .HRESETn(rst_n), .bus(if_ws3));

  always_comb begin
    case (sel)
      0:       begin o_rdata = if_ws0.HRDATA; o_ready = if_ws0.HREADY; o_resp = if_ws0.HRESP; end
      1:       begin o_rdata = if_ws1.HRDATA; o_ready = if_ws1.HREADY; o_resp = if_ws1.HRESP; end
      default: begin o_rdata = if_ws3.HRDATA; o_ready = if_ws3.HREADY; o_resp = if_ws3.HRESP; end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    hsel   = 1'b0;
    htrans = 2'd0;
    hwrite = 1'b0;
  endtask

  task automatic addr_phase(input logic wr, input logic [31:0] a);
    hsel   = 1'b1;
    htrans = 2'd2;
    hwrite = wr;
    haddr  = a;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (o_ready !== 1'b1 && n < 32) begin
      cyc();
      n++;
    end
    check({tag, "_ready_timeout"}, 32'(o_ready), 32'h1);
  endtask

  task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d);
    addr_phase(1'b1, a);
    cyc();
    bus_idle();
    hwdata = d;
    wait_ready(tag);
    cyc();
  endtask

  task automatic do_read(input string tag, input logic [31:0] a, output logic [31:0] d);
    addr_phase(1'b0, a);
    cyc();
    bus_idle();
    wait_ready(tag);
    d = o_rdata;
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    bus_idle();
    haddr  = 32'h0;
    hwdata = 32'h0;
    sel    = 1;
    repeat (3) cyc();

    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check("rst_hready", 32'(o_ready), 32'h1);
      check("rst_hresp",  32'(o_resp),  32'h0);
      check("rst_hrdata", o_rdata,      32'h0);
    end
    rst_n = 1'b1;
    cyc();

    // One wait state: write then read back the same word.
    sel = 1;
    addr_phase(1'b1, 32'h10);
    check("ws1_wr_addr_ready", 32'(o_ready), 32'h1);
    cyc();
    bus_idle();
    hwdata = 32'hDEADBEEF;
    check("ws1_wr_stall", 32'(o_ready), 32'h0);
    cyc();
    check("ws1_wr_data_ready", 32'(o_ready), 32'h1);
    check("ws1_wr_rdata_zero", o_rdata, 32'h0);
    addr_phase(1'b0, 32'h10);
    cyc();
    bus_idle();
    check("ws1_rd_stall", 32'(o_ready), 32'h0);
    check("ws1_rd_stall_rdata", o_rdata, 32'h0);
    cyc();
    check("ws1_rd_ready", 32'(o_ready), 32'h1);
    check("ws1_rd_data", o_rdata, 32'hDEADBEEF);
    cyc();
    check("ws1_idle_ready", 32'(o_ready), 32'h1);
    check("ws1_idle_rdata", o_rdata, 32'h0);

    // Zero wait states: read address phase overlaps the write data phase.
    sel = 0;
    addr_phase(1'b1, 32'h20);
    cyc();
    hwdata = 32'h12345678;
    addr_phase(1'b0, 32'h20);
    check("ws0_wr_ready", 32'(o_ready), 32'h1);
    cyc();
    bus_idle();
    check("ws0_rd_ready", 32'(o_ready), 32'h1);
    check("ws0_rd_data", o_rdata, 32'h12345678);
    cyc();
    check("ws0_idle_ready", 32'(o_ready), 32'h1);
    check("ws0_idle_rdata", o_rdata, 32'h0);

    // Three wait states: held NONSEQ read with changing HWDATA during the stall.
    sel = 2;
    addr_phase(1'b1, 32'h30);
    cyc();
    bus_idle();
    hwdata = 32'hA5A50003;
    for (int i = 0; i < 3; i++) begin
      check("ws3_wr_stall", 32'(o_ready), 32'h0);
      cyc();
    end
    check("ws3_wr_ready", 32'(o_ready), 32'h1);
    addr_phase(1'b0, 32'h30);
    cyc();
    for (int i = 0; i < 3; i++) begin
      check("ws3_rd_stall", 32'(o_ready), 32'h0);
      hwdata = 32'(32'h11111111 * (i + 1));
      cyc();
    end
    check("ws3_rd_ready", 32'(o_ready), 32'h1);
    check("ws3_rd_data", o_rdata, 32'hA5A50003);
    bus_idle();
    cyc();
    check("ws3_rd_done_ready", 32'(o_ready), 32'h1);

    // IDLE, BUSY and deselected NONSEQ must not transfer.
    sel    = 1;
    hwdata = 32'h0;
    hsel   = 1'b1;
    htrans = 2'd0;
    hwrite = 1'b1;
    haddr  = 32'h10;
    cyc();
    check("idle_ready", 32'(o_ready), 32'h1);
    check("idle_resp",  32'(o_resp),  32'h0);
    htrans = 2'd1;
    cyc();
    check("busy_ready", 32'(o_ready), 32'h1);
    check("busy_resp",  32'(o_resp),  32'h0);
    hsel   = 1'b0;
    htrans = 2'd2;
    cyc();
    check("nosel_ready", 32'(o_ready), 32'h1);
    check("nosel_resp",  32'(o_resp),  32'h0);
    bus_idle();
    cyc();
    do_read("noxfer_rd", 32'h10, rd);
    check("noxfer_mem", rd, 32'hDEADBEEF);

    // Reset asserted in the middle of a write stall.
    sel = 2;
    addr_phase(1'b1, 32'h30);
    cyc();
    bus_idle();
    hwdata = 32'hBAD00000;
    check("rstmid_stall", 32'(o_ready), 32'h0);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_hready", 32'(o_ready), 32'h1);
    check("rstmid_hresp",  32'(o_resp),  32'h0);
    check("rstmid_hrdata", o_rdata,      32'h0);
    cyc();
    rst_n = 1'b1;
    cyc();
    do_read("rstmid_rd", 32'h30, rd);
    check("rstmid_mem", rd, 32'hA5A50003);

    // Out-of-range write: ERROR response with the macro, wrap into word 0 without.
    sel = 1;
    do_write("oor_pre", 32'h0, 32'h00000A0A);
    addr_phase(1'b1, 32'h00001000);
    cyc();
    bus_idle();
    hwdata = 32'hCAFE0001;
    check("oor_first_ready", 32'(o_ready), 32'h0);
    check("oor_first_resp",  32'(o_resp),  32'(ERR_EN));
    cyc();
    check("oor_second_ready", 32'(o_ready), 32'h1);
    check("oor_second_resp",  32'(o_resp),  32'(ERR_EN));
    check("oor_rdata",        o_rdata,      32'h0);
    cyc();
    check("oor_after_resp", 32'(o_resp), 32'h0);
    do_read("oor_rd", 32'h0, rd);
    check("oor_word0", rd, ERR_EN ? 32'h00000A0A : 32'hCAFE0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_mem_slave.md
Name: ahb_mem_slave

Overview:
- Word-addressed AHB-Lite memory slave. Sits directly downstream of the AHB master stage.
- Consumes the master's HADDR/HWRITE/HWDATA and returns HRDATA/HREADY, which close the master's read and write handshakes.
- Provides programmable wait states so the master's HREADY stall paths are exercised.
- Top level ties HSEL/HTRANS from the decoder, or from constants for a single-slave system.

Parameters:
- ADDR_WIDTH, 10, word-index bits; memory depth = 2**ADDR_WIDTH words of 32 bits.
- WAIT_STATES, 1, HREADY-low cycles inserted per OKAY data phase (0..15).

Ports:
- HCLK  input  1  system clock, rising edge.
- HRESETn  input  1  reset, asynchronous, active-low.
- HSEL  input  1  slave select.
- HTRANS  input  2  transfer type: 0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ.
- HWRITE  input  1  1 = write, 0 = read; sampled in address phase.
- HADDR  input  32  byte address; bits [1:0] ignored.
- HWDATA  input  32  write data, valid in data phase.
- HRDATA  output  32  read data, valid when HREADY=1 in a read data phase.
- HREADY  output  1  transfer complete / slave ready for next address phase.
- HRESP  output  1  0 OKAY, 1 ERROR.

Behaviour:
- Reset (async, HRESETn=0):
  - state IDLE, wait counter 0, latched address/write cleared.
  - HREADY=1, HRESP=0, HRDATA=0.
  - Memory contents are not cleared.
- Address-phase accept occurs at a rising edge when HSEL=1 and HTRANS[1]=1 and HREADY=1. On accept, latch index = HADDR[ADDR_WIDTH+1:2] and the HWRITE value.
- IDLE or BUSY transfers, or HSEL=0: nothing is latched. The next cycle is a zero-wait OKAY (HREADY=1, HRESP=0, HRDATA=0).
- State machine: IDLE, WAIT, DATA (plus ERR1, ERR2 with the optional feature).
  - IDLE -> WAIT on accept when WAIT_STATES>0, with counter loaded to WAIT_STATES.
  - IDLE -> DATA on accept when WAIT_STATES=0.
  - WAIT: HREADY=0, HRESP=0, HRDATA=0. Counter decrements each cycle; WAIT -> DATA when the counter reaches 1.
  - DATA: HREADY=1, HRESP=0, so the data phase completes this cycle.
    - Read: HRDATA = mem[latched index], combinational from the array.
    - Write: mem[latched index] <= HWDATA at the closing edge.
    - A new accept in the same cycle (pipelined address phase) -> WAIT or DATA as from IDLE; otherwise -> IDLE.
- While HREADY=0, address-phase inputs are ignored; the master holds them stable.
- OKAY data-phase length = WAIT_STATES+1 cycles.
- Back-to-back write then read to the same address: the write commits at the end of its data phase, before the read's data phase, so the read returns the new data. No forwarding is needed.
- HRDATA=0 in every cycle that is not a read DATA cycle.
- Reset mid-transfer: the pending write is discarded and the memory word is unchanged. Outputs return to reset values immediately.

Optional Feature:
- Macro: AHB_MEM_ERROR_RESP_EN.
- Defined: an accepted address with HADDR[31:ADDR_WIDTH+2] != 0 is out of range.
  - Wait states are skipped: ERR1 (HREADY=0, HRESP=1), then ERR2 (HREADY=1, HRESP=1).
  - No memory write occurs; HRDATA=0.
  - An accept in ERR2 is processed normally.
- Undefined: upper address bits are ignored and the address wraps modulo depth. HRESP is tied 0 and the ERR states are absent.

Test Plan:
- Reset: HRESETn=0 asynchronously mid-WAIT -> HREADY=1, HRESP=0, HRDATA=0 within the same cycle. Pending write is not committed.
- WAIT_STATES=1: write HADDR=0x10, HWDATA=0xDEADBEEF, then read 0x10 -> each data phase is HREADY low 1 cycle, then high. Read HRDATA=0xDEADBEEF.
- WAIT_STATES=0: pipelined write 0x20 = 0x12345678 with address-phase read 0x20 in the next cycle -> read returns 0x12345678. HREADY stays 1 throughout.
- WAIT_STATES=3: HTRANS=NONSEQ read held with a changing HWDATA -> HREADY low exactly 3 cycles, and inputs during the stall do not start a new transfer.
- HTRANS=IDLE and BUSY with HSEL=1, and NONSEQ with HSEL=0 -> no memory change, HREADY=1, HRESP=0.
- With AHB_MEM_ERROR_RESP_EN and ADDR_WIDTH=10: write to 0x00001000 -> HREADY 0 then 1 with HRESP=1 for both cycles; word 0 unchanged. Without the macro, the same write lands in word 0.
